// File: rtl/link_pkg.sv
// Shared constants for the byte-link arbiter and related shared-resource controllers.
package link_pkg;

  localparam logic [2:0] IDLE     = 3'h0;
  localparam logic [2:0] WAIT_ACK = 3'h1;
  localparam logic [2:0] WAIT_REL = 3'h2;
  localparam logic [2:0] ABORT    = 3'h3;
  localparam logic [2:0] FINISH   = 3'h4;

  localparam int DATA_W_DEF = 8;

  // Bits needed to hold values 0..value-1; used for elaboration-time sizing only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/link_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above the pointer wins,
// wrapping to the lowest set bit below it.
module rr_pick
  import link_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = {N{1'b0}};
    idx_o = {IDX_W{1'b0}};
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end else begin
        found = found;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/link_arbiter.sv
// Round-robin owner of the rdy/data/ack byte link: grants one requester at a time,
// runs the 4-phase handshake and reports done or timeout per requester.
module link_arbiter
  import link_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o,
  output logic                    rdy_o,
  output logic [DATA_W-1:0]       data_o,
  input  logic                    ack_i
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int TMR_W = clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(ACK_TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_q, rdy_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    done_d  = {N_REQ{1'b0}};
    err_d   = {N_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          grant_d = pick_gnt;
          data_d  = req_data_i[pick_idx * DATA_W +: DATA_W];
          rdy_d   = 1'b1;
          timer_d = {TMR_W{1'b0}};
          state_d = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        // A stale ack already high on entry is taken as the real one.
        if (ack_i) begin
          rdy_d   = 1'b0;
          timer_d = {TMR_W{1'b0}};
          state_d = WAIT_REL;
        end else if (timer_q == TMR_MAX) begin
          rdy_d   = 1'b0;
          state_d = ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_REL: begin
        if (!ack_i) begin
          done_d  = grant_q;
          state_d = FINISH;
        end else if (timer_q == TMR_MAX) begin
          state_d = ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ABORT: begin
        err_d   = grant_q;
        state_d = FINISH;
      end
      FINISH: begin
        grant_d = {N_REQ{1'b0}};
        ptr_d   = (owner_q == PTR_LAST) ? {PTR_W{1'b0}} : owner_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = {TMR_W{1'b0}};
        ptr_d   = {PTR_W{1'b0}};
        owner_d = {PTR_W{1'b0}};
        grant_d = {N_REQ{1'b0}};
        data_d  = {DATA_W{1'b0}};
        rdy_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= {TMR_W{1'b0}};
      ptr_q   <= {PTR_W{1'b0}};
      owner_q <= {PTR_W{1'b0}};
      grant_q <= {N_REQ{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      rdy_q   <= 1'b0;
      done_q  <= {N_REQ{1'b0}};
      err_q   <= {N_REQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign done_o  = done_q;
  assign err_o   = err_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;
  assign rdy_o   = rdy_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: directed requests, receiver model with
// normal / never-ack / stuck-ack behaviour, and a link/completion monitor.
module tb_link_arbiter;

  localparam int RX_NORMAL = 0;
  localparam int RX_NEVER  = 1;
  localparam int RX_HOLD   = 2;

  typedef struct {
    logic [7:0] data;
    logic [3:0] grant;
    int         len;
  } link_t;

  typedef struct {
    logic       is_err;
    logic [3:0] vec;
  } cmp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic [3:0]  done_o;
  logic [3:0]  err_o;
  logic [3:0]  grant_o;
  logic        busy_o;
  logic        rdy_o;
  logic [7:0]  data_o;
  logic        ack_i;

  int    total;
  int    passed;
  int    rx_mode;
  link_t link_q[$];
  cmp_t  cmp_q[$];

  link_arbiter #(
    .N_REQ       (4),
    .DATA_W      (8),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .rdy_o      (rdy_o),
    .data_o     (data_o),
    .ack_i      (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_link(input logic [7:0] d, input logic [3:0] g, input int len);
    link_t t;
    t.data  = d;
    t.grant = g;
    t.len   = len;
    link_q.push_back(t);
  endtask

  task automatic push_cmp(input logic is_err, input logic [3:0] v);
    cmp_t c;
    c.is_err = is_err;
    c.vec    = v;
    cmp_q.push_back(c);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!((|done_o) || (|err_o)) && n < 60);
    check({name, "_pulse_seen"}, 32'((|done_o) || (|err_o)), 32'd1);
  endtask

  task automatic wait_rdy(input string name);
    int n;
    n = 0;
    while (!rdy_o && n < 10) begin
      step();
      n++;
    end
    check({name, "_rdy_seen"}, 32'(rdy_o), 32'd1);
  endtask

  // Receiver model: raises ack after rdy has been seen high 3 times, drops it
  // after rdy has been seen low twice.
  initial begin
    int hi;
    int lo;
    ack_i = 1'b0;
    hi = 0;
    lo = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ack_i = 1'b0;
        hi = 0;
        lo = 0;
      end else begin
        if (rdy_o) begin
          hi++;
          lo = 0;
        end else begin
          lo++;
          hi = 0;
        end
        case (rx_mode)
          RX_NEVER: ack_i = 1'b0;
          RX_HOLD: begin
            if (rdy_o && hi >= 3) ack_i = 1'b1;
          end
          default: begin
            if (rdy_o && hi >= 3) ack_i = 1'b1;
            else if (!rdy_o && lo >= 2) ack_i = 1'b0;
          end
        endcase
      end
    end
  end

  // Monitor: checks each rdy pulse and each done/err pulse against the queues.
  initial begin
    logic       prev_rdy;
    logic       after_pulse;
    logic [7:0] cur_data;
    int         cur_len;
    int         hi_len;
    link_t      t;
    cmp_t       c;
    prev_rdy = 1'b0;
    after_pulse = 1'b0;
    cur_data = 8'h00;
    cur_len = -1;
    hi_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b0;
        after_pulse = 1'b0;
        cur_len = -1;
        hi_len = 0;
      end else begin
        if (after_pulse) begin
          check("grant_clear_after_pulse", 32'(grant_o), 32'd0);
          after_pulse = 1'b0;
        end
        if (rdy_o && !prev_rdy) begin
          if (link_q.size() == 0) begin
            check("unexpected_rdy", 32'd1, 32'd0);
            cur_data = data_o;
            cur_len = -1;
          end else begin
            t = link_q.pop_front();
            check("rise_data", 32'(data_o), 32'(t.data));
            check("rise_grant", 32'(grant_o), 32'(t.grant));
            cur_data = t.data;
            cur_len = t.len;
          end
          hi_len = 0;
        end
        if (rdy_o) begin
          hi_len++;
          if (data_o !== cur_data) check("data_stable", 32'(data_o), 32'(cur_data));
        end
        if (!rdy_o && prev_rdy && cur_len >= 0) begin
          check("rdy_len", 32'(hi_len), 32'(cur_len));
        end
        if ((|done_o) || (|err_o)) begin
          if (cmp_q.size() == 0) begin
            check("unexpected_pulse", {24'd0, done_o, err_o}, 32'd0);
          end else begin
            c = cmp_q.pop_front();
            check("pulse_done", 32'(done_o), c.is_err ? 32'd0 : 32'(c.vec));
            check("pulse_err", 32'(err_o), c.is_err ? 32'(c.vec) : 32'd0);
            check("pulse_grant", 32'(grant_o), 32'(c.vec));
          end
          after_pulse = 1'b1;
        end
        prev_rdy = rdy_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    passed = 0;
    rx_mode = RX_NORMAL;
    rst = 1'b1;
    req_i = 4'b0000;
    req_data_i = 32'h0;
    #2;
    check("rst_rdy", 32'(rdy_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // All four requesting: pointer 0, rotation 0,1,2,3,0,1,2,3.
    req_data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 8; k++) begin
      push_link(8'h10 + 8'(k % 4), 4'(4'b0001 << (k % 4)), 3);
      push_cmp(1'b0, 4'(4'b0001 << (k % 4)));
    end
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_pulse("rotate");
    end
    req_i = 4'b0000;
    step();
    step();

    // Single request on index 2; rdy one cycle after req.
    req_data_i = 32'h00A5_0000;
    push_link(8'hA5, 4'b0100, 3);
    push_cmp(1'b0, 4'b0100);
    req_i = 4'b0100;
    check("single_rdy_before", 32'(rdy_o), 32'd0);
    @(posedge clk);
    #1;
    check("single_rdy_latency", 32'(rdy_o), 32'd1);
    wait_pulse("single");
    check("single_done", 32'(done_o), 32'b0100);
    req_i = 4'b0000;
    step();
    step();

    // Never-ack timeout on index 0, then index 1 served normally.
    rx_mode = RX_NEVER;
    req_data_i = 32'h0000_665A;
    push_link(8'h5A, 4'b0001, 9);
    push_cmp(1'b1, 4'b0001);
    push_link(8'h66, 4'b0010, 3);
    push_cmp(1'b0, 4'b0010);
    req_i = 4'b0011;
    wait_pulse("noack");
    check("noack_err", 32'(err_o), 32'b0001);
    req_i = 4'b0010;
    rx_mode = RX_NORMAL;
    wait_pulse("after_noack");
    req_i = 4'b0000;
    step();
    step();

    // Ack stuck high: abort from WAIT_REL on index 3.
    rx_mode = RX_HOLD;
    req_data_i = 32'hC300_0000;
    push_link(8'hC3, 4'b1000, 3);
    push_cmp(1'b1, 4'b1000);
    req_i = 4'b1000;
    wait_pulse("stuck_ack");
    check("stuck_ack_err", 32'(err_o), 32'b1000);
    req_i = 4'b0000;
    rx_mode = RX_NORMAL;
    step();
    step();
    step();
    check("stuck_ack_idle", 32'(busy_o), 32'd0);

    // Owner drops req and changes its byte mid-transfer.
    req_data_i = 32'h0000_3C00;
    push_link(8'h3C, 4'b0010, 3);
    push_cmp(1'b0, 4'b0010);
    req_i = 4'b0010;
    wait_rdy("drop");
    step();
    req_i = 4'b0000;
    req_data_i = 32'h0000_FF00;
    wait_pulse("drop");
    check("drop_done", 32'(done_o), 32'b0010);
    step();
    step();

    // Reset during WAIT_ACK, then lowest set index wins.
    req_data_i = 32'h0072_7100;
    push_link(8'h72, 4'b0100, -1);
    req_i = 4'b0110;
    wait_rdy("rst_mid");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_rdy", 32'(rdy_o), 32'd0);
    check("rst_mid_grant", 32'(grant_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_pulse", {24'd0, done_o, err_o}, 32'd0);
    step();
    step();
    push_link(8'h71, 4'b0010, 3);
    push_cmp(1'b0, 4'b0010);
    rst = 1'b0;
    wait_pulse("post_rst");
    req_i = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    check("final_idle", 32'(busy_o), 32'd0);
    check("link_q_drained", 32'(link_q.size()), 32'd0);
    check("cmp_q_drained", 32'(cmp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
